// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external registered adder among N requesters.
// One operation in flight: IDLE grants, ISSUE drives the adder, CAPT samples it, RESP hands back.
module adder_arbiter #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int IDW = 2,
   parameter int CW  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req_valid,
   output logic [N-1:0]           req_ready,
   input  logic [N*(2*W+1)-1:0]   req_opnd,
   output logic [2*W:0]           add_ins,
   input  logic [W+1:0]           add_sm_r,
   input  logic                   add_zero_r,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [W+1:0]           rsp_sum,
   output logic                   rsp_zero,
   output logic                   busy,
   output logic [CW-1:0]          op_cnt
);

   localparam int OW = 2*W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [OW-1:0]   op_q, op_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [W+1:0]    rsp_sum_q, rsp_sum_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic [CW-1:0]   op_cnt_q, op_cnt_d;

   logic [IDW-1:0]  grant;
   logic [IDW-1:0]  idx;
   logic            grant_vld;

   // Walk downward from ptr+N to ptr+1 so the candidate closest after ptr is assigned last and wins.
   always_comb begin
      grant     = ptr_q;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IDW'((int'(ptr_q) + k) % N);
         if (req_valid[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      op_d       = op_q;
      rsp_id_d   = rsp_id_q;
      rsp_sum_d  = rsp_sum_q;
      rsp_zero_d = rsp_zero_q;
      op_cnt_d   = op_cnt_q;
      req_ready  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_vld && !rst) begin
               req_ready[grant] = 1'b1;
               op_d             = req_opnd[int'(grant)*OW +: OW];
               id_d             = grant;
               ptr_d            = grant;
               state_d          = ISSUE;
            end
         end
         ISSUE: state_d = CAPT;
         CAPT: begin
            rsp_sum_d  = add_sm_r;
            rsp_zero_d = add_zero_r;
            rsp_id_d   = id_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               op_cnt_d = op_cnt_q + 1'b1;
               state_d  = IDLE;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= IDW'(N - 1);
         id_q       <= '0;
         op_q       <= '0;
         rsp_id_q   <= '0;
         rsp_sum_q  <= '0;
         rsp_zero_q <= 1'b0;
         op_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         op_q       <= op_d;
         rsp_id_q   <= rsp_id_d;
         rsp_sum_q  <= rsp_sum_d;
         rsp_zero_q <= rsp_zero_d;
         op_cnt_q   <= op_cnt_d;
      end
   end

   assign add_ins   = op_q;
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_zero  = rsp_zero_q;
   assign op_cnt    = op_cnt_q;

endmodule
